// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - elastic valid/ready pipeline-register chain with flush and occupancy
module elastic_pipe_reg #(
    parameter int                 WIDTH   = 32,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] inc_v;
    logic [WIDTH-1:0] inc_d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage may advance if it is empty or the stage ahead of it advances,
    // which is what lets bubbles collapse while the output is stalled.
    always_comb begin
        logic a;
        adv = '0;
        a = !v_q[DEPTH-1] | out_ready;
        adv[DEPTH-1] = a;
        for (int k = DEPTH-2; k >= 0; k--) begin
            a = !v_q[k] | a;
            adv[k] = a;
        end
    end

    always_comb begin
        inc_v = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inc_d[k] = '0;
        end
        inc_v[0] = in_valid;
        inc_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            inc_v[k] = v_q[k-1];
            inc_d[k] = d_q[k-1];
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        v_d     = v_q;
        count_d = count_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end
        if (flush) begin
            v_d     = '0;
            count_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = RST_VAL;
            end
        end else begin
            // Payload only loads under a valid incoming entry so empty stages keep stale data stable.
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_d[k] = inc_v[k];
                    if (inc_v[k]) begin
                        d_d[k] = inc_d[k];
                    end
                end
            end
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RST_VAL;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - self-checking bench for elastic_pipe_reg (WIDTH=8, DEPTH=3, RST_VAL=A5)
module tb_elastic_pipe_reg;

    localparam int          W  = 8;
    localparam int          D  = 3;
    localparam logic [7:0]  RV = 8'hA5;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                        input logic e_ir, input logic e_ov, input logic [7:0] e_od, input logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] q[$];

    initial begin
        // streaming, out_ready=1
        addv(1, 8'h01, 1, 0, 1, 0, 8'hA5, 0);
        addv(1, 8'h02, 1, 0, 1, 0, 8'hA5, 1);
        addv(1, 8'h03, 1, 0, 1, 0, 8'hA5, 2);
        addv(1, 8'h04, 1, 0, 1, 1, 8'h01, 3);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h02, 3);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h03, 2);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h04, 1);
        addv(0, 8'h00, 1, 0, 1, 0, 8'h04, 0);
        // backpressure then release
        addv(1, 8'h10, 0, 0, 1, 0, 8'h04, 0);
        addv(1, 8'h11, 0, 0, 1, 0, 8'h04, 1);
        addv(1, 8'h12, 0, 0, 1, 0, 8'h04, 2);
        addv(1, 8'h13, 0, 0, 0, 1, 8'h10, 3);
        addv(1, 8'h13, 0, 0, 0, 1, 8'h10, 3);
        addv(1, 8'h13, 1, 0, 1, 1, 8'h10, 3);
        addv(1, 8'h14, 1, 0, 1, 1, 8'h11, 3);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h12, 3);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h13, 2);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h14, 1);
        addv(0, 8'h00, 1, 0, 1, 0, 8'h14, 0);
        // bubble collapse
        addv(1, 8'h21, 0, 0, 1, 0, 8'h14, 0);
        addv(0, 8'h00, 0, 0, 1, 0, 8'h14, 1);
        addv(0, 8'h00, 0, 0, 1, 0, 8'h14, 1);
        addv(1, 8'h22, 0, 0, 1, 1, 8'h21, 1);
        addv(0, 8'h00, 0, 0, 1, 1, 8'h21, 2);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h21, 2);
        addv(0, 8'h00, 1, 0, 1, 1, 8'h22, 1);
        addv(0, 8'h00, 1, 0, 1, 0, 8'h22, 0);
        // flush of a full chain with a pending input
        addv(1, 8'h31, 0, 0, 1, 0, 8'h22, 0);
        addv(1, 8'h32, 0, 0, 1, 0, 8'h22, 1);
        addv(1, 8'h33, 0, 0, 1, 0, 8'h22, 2);
        addv(1, 8'h34, 0, 1, 0, 1, 8'h31, 3);
        addv(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0);
        addv(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0);
        addv(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0);

        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 8'hA5);
        chk("reset count", count, 0);
        chk("reset in_ready", in_ready, 1);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("vec%0d count", i), count, tbl[i].e_cnt);
            tick();
        end
        flush = 1'b0;

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h50;
        tick();
        in_data = 8'h51;
        tick();
        in_valid = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 8'hA5);
        chk("midrst count", count, 0);
        chk("midrst in_ready", in_ready, 1);
        tick();
        nRST = 1'b1;
        #1;
        chk("postrst in_ready", in_ready, 1);
        tick();
        chk("postrst out_valid", out_valid, 0);
        chk("postrst count", count, 0);

        // randomised traffic against a reference queue
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (c < 40) out_ready = (c % 8 == 7);
            #1;
            chk("rnd count", count, q.size());
            chk("rnd in_ready", in_ready, (q.size() < D) || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd spurious out_valid", out_valid, 0);
                end else begin
                    chk("rnd out_data", out_data, q[0]);
                end
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
            tick();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid && q.size() > 0) begin
                chk("drain out_data", out_data, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        chk("drain out_valid", out_valid, 0);
        chk("drain count", count, 0);
        chk("drain leftover", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
